// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the program loader.
//                Holds the FSM state type, the default memory geometry
//                and the idle values driven onto the SRAM write ports.
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    // Default geometry: two SRAMs (IM then DM) of 2**14 words each.
    localparam int          c_DEF_WORDS_PER_MEM = 16384;
    localparam int          c_DEF_ADDR_W        = 14;

    // SRAM idle: chip and write enables high, every bit write-masked.
    localparam logic        c_CEB_IDLE  = 1'b1;
    localparam logic        c_WEB_IDLE  = 1'b1;
    localparam logic [31:0] c_BWEB_IDLE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader. Packs a little-endian byte stream
//                into 32-bit words and writes them first through the IM
//                SRAM, then through the DM SRAM. Holds the CPU in reset
//                until the image is complete.
//  Ports       : clk, rst                       clock, sync active-high reset
//                in_valid/in_data/in_last/in_ready  byte-stream handshake
//                im_CEB/WEB/BWEB/A/DI           IM write port (active-low)
//                dm_CEB/WEB/BWEB/A/DI           DM write port (active-low)
//                cpu_rst                        CPU core reset (1 while loading)
//                done                           load complete
//  Revision    : 1.0  initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int WORDS_PER_MEM = c_DEF_WORDS_PER_MEM,
    parameter int ADDR_W        = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              im_CEB,
    output logic              im_WEB,
    output logic [31:0]       im_BWEB,
    output logic [ADDR_W-1:0] im_A,
    output logic [31:0]       im_DI,
    output logic              dm_CEB,
    output logic              dm_WEB,
    output logic [31:0]       dm_BWEB,
    output logic [ADDR_W-1:0] dm_A,
    output logic [31:0]       dm_DI,
    output logic              cpu_rst,
    output logic              done
);

    // Index of the final word across both memories.
    localparam logic [ADDR_W:0] c_LAST_WORD = (ADDR_W+1)'(2*WORDS_PER_MEM-1);

    state_t          r_state;
    state_t          w_next_state;
    logic [ADDR_W:0] r_word_cnt;
    logic [2:0]      r_byte_cnt;   // lanes filled so far (0..4)
    logic [31:0]     r_asm;
    logic            r_last;       // current word was closed by in_last

    logic            w_accept;
    logic            w_word_end;
    logic            w_final;
    logic            w_write;
    logic [31:0]     w_bweb;

    assign w_accept   = (r_state == ST_LOAD) && in_valid;
    assign w_word_end = w_accept && ((r_byte_cnt == 3'd3) || in_last);
    assign w_final    = r_last || (r_word_cnt == c_LAST_WORD);
    // A reset sampled during the write cycle must suppress that write.
    assign w_write    = (r_state == ST_WRITE) && !rst;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD:  if (w_word_end) w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = w_final ? ST_DONE : ST_LOAD;
            ST_DONE:  w_next_state = ST_DONE;
            default:  w_next_state = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Word assembly and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_asm[{r_byte_cnt[1:0], 3'b000} +: 8] <= in_data;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_last     <= in_last;
                    end
                end
                ST_WRITE: begin
                    // On the final word everything holds; DONE never reads it.
                    if (!w_final) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                        r_last     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lanes at or above the received byte count are masked off. Their DI
    // bytes are already zero because the assembly register is cleared
    // between words.
    always_comb begin
        w_bweb = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_byte_cnt <= 3'(i)) begin
                w_bweb[8*i +: 8] = 8'hFF;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == ST_LOAD);
        done     = (r_state == ST_DONE);
        cpu_rst  = (r_state != ST_DONE);

        im_CEB  = c_CEB_IDLE;
        im_WEB  = c_WEB_IDLE;
        im_BWEB = c_BWEB_IDLE;
        im_A    = '0;
        im_DI   = '0;
        dm_CEB  = c_CEB_IDLE;
        dm_WEB  = c_WEB_IDLE;
        dm_BWEB = c_BWEB_IDLE;
        dm_A    = '0;
        dm_DI   = '0;

        if (w_write) begin
            if (r_word_cnt[ADDR_W]) begin
                dm_CEB  = 1'b0;
                dm_WEB  = 1'b0;
                dm_BWEB = w_bweb;
                dm_A    = r_word_cnt[ADDR_W-1:0];
                dm_DI   = r_asm;
            end else begin
                im_CEB  = 1'b0;
                im_WEB  = 1'b0;
                im_BWEB = w_bweb;
                im_A    = r_word_cnt[ADDR_W-1:0];
                im_DI   = r_asm;
            end
        end
    end

endmodule : prog_loader
`default_nettype wire
